// File: rtl/tri_pixel_buffer.sv
// Captures rasterizer points into an N x N bitmap, then drains it one row per
// handshake and reports pixel count, duplicate writes and overrun.
module tri_pixel_buffer #(
    parameter int COORD_W = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        busy_in,
    input  logic                        po,
    input  logic [COORD_W-1:0]          xo,
    input  logic [COORD_W-1:0]          yo,
    input  logic                        rd_ready,
    output logic                        row_valid,
    output logic [COORD_W-1:0]          row_idx,
    output logic [(1<<COORD_W)-1:0]     row_data,
    output logic [2*COORD_W:0]          pix_cnt,
    output logic                        frame_done,
    output logic                        dup_err,
    output logic                        ovr_err
);
    localparam int N     = 1 << COORD_W;
    localparam int CNT_W = 2 * COORD_W + 1;
    localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(N - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DRAIN, S_DONE} state_t;

    state_t                     state_q, state_d;
    logic                       busy_dly_q, busy_dly_d;
    logic [N-1:0][N-1:0]        bitmap_q, bitmap_d;
    logic [COORD_W-1:0]         row_idx_q, row_idx_d;
    logic [CNT_W-1:0]           pix_cnt_q, pix_cnt_d;
    logic                       dup_q, dup_d;
    logic                       ovr_q, ovr_d;
    logic                       rise, fall, cap_en;

    assign rise = busy_in & ~busy_dly_q;
    assign fall = ~busy_in & busy_dly_q;

    always_comb begin
        state_d    = state_q;
        busy_dly_d = busy_in;
        bitmap_d   = bitmap_q;
        row_idx_d  = row_idx_q;
        pix_cnt_d  = pix_cnt_q;
        dup_d      = dup_q;
        ovr_d      = ovr_q;
        cap_en     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    state_d   = S_CAPTURE;
                    pix_cnt_d = '0;
                    dup_d     = 1'b0;
                    cap_en    = po;
                end
            end
            S_CAPTURE: begin
                cap_en = po;
                if (fall) begin
                    state_d   = S_DRAIN;
                    row_idx_d = '0;
                end
            end
            S_DRAIN: begin
                if (rise) ovr_d = 1'b1;
                if (rd_ready) begin
                    if (row_idx_q == LAST_ROW) state_d = S_DONE;
                    else                       row_idx_d = row_idx_q + 1'b1;
                end
            end
            S_DONE: begin
                // Clear happens before any same-cycle capture so a new frame
                // starting here lands in an empty bitmap.
                bitmap_d  = '0;
                row_idx_d = '0;
                state_d   = S_IDLE;
                if (rise) begin
                    state_d   = S_CAPTURE;
                    pix_cnt_d = '0;
                    dup_d     = 1'b0;
                    cap_en    = po;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (cap_en) begin
            if (bitmap_d[yo][xo]) begin
                dup_d = 1'b1;
            end else begin
                bitmap_d[yo][xo] = 1'b1;
                pix_cnt_d        = pix_cnt_d + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            busy_dly_q <= 1'b0;
            bitmap_q   <= '0;
            row_idx_q  <= '0;
            pix_cnt_q  <= '0;
            dup_q      <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_dly_q <= busy_dly_d;
            bitmap_q   <= bitmap_d;
            row_idx_q  <= row_idx_d;
            pix_cnt_q  <= pix_cnt_d;
            dup_q      <= dup_d;
            ovr_q      <= ovr_d;
        end
    end

    assign row_valid  = (state_q == S_DRAIN);
    assign row_idx    = row_idx_q;
    assign row_data   = row_valid ? bitmap_q[row_idx_q] : '0;
    assign pix_cnt    = pix_cnt_q;
    assign frame_done = (state_q == S_DONE);
    assign dup_err    = dup_q;
    assign ovr_err    = ovr_q;
endmodule

// File: tb/tb_tri_pixel_buffer.sv
// Bench for tri_pixel_buffer: fixed vector table, directed corner sequences and
// randomized frames checked against a set-based pixel model.
module tb_tri_pixel_buffer;
    localparam int CW    = 3;
    localparam int N     = 1 << CW;
    localparam int CNT_W = 2 * CW + 1;

    logic             clk = 1'b0;
    logic             reset, busy_in, po, rd_ready;
    logic [CW-1:0]    xo, yo;
    logic             row_valid, frame_done, dup_err, ovr_err;
    logic [CW-1:0]    row_idx;
    logic [N-1:0]     row_data;
    logic [CNT_W-1:0] pix_cnt;

    always #5 clk = ~clk;

    tri_pixel_buffer #(.COORD_W(CW)) dut (
        .clk(clk), .reset(reset), .busy_in(busy_in), .po(po), .xo(xo), .yo(yo),
        .rd_ready(rd_ready), .row_valid(row_valid), .row_idx(row_idx),
        .row_data(row_data), .pix_cnt(pix_cnt), .frame_done(frame_done),
        .dup_err(dup_err), .ovr_err(ovr_err)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(input bit b, input bit p, input int x, input int y, input bit r);
        busy_in  = b;
        po       = p;
        rd_ready = r;
        if (p) begin
            xo = x[CW-1:0];
            yo = y[CW-1:0];
        end else begin
            xo = 'x;
            yo = 'x;
        end
        @(posedge clk);
        #1;
    endtask

    // Reference model: a frame is the set of distinct pixels it touched.
    int seen[int];
    bit exp_dup;
    bit exp_ovr;
    int qx[$];
    int qy[$];

    function automatic void model_clear();
        seen.delete();
        exp_dup = 1'b0;
        qx.delete();
        qy.delete();
    endfunction

    function automatic void add_pt(input int x, input int y);
        qx.push_back(x);
        qy.push_back(y);
        if (seen.exists(y * N + x)) exp_dup = 1'b1;
        else                        seen[y * N + x] = 1;
    endfunction

    function automatic int exp_row(input int r);
        int v;
        v = 0;
        foreach (seen[k]) if (k / N == r) v |= (1 << (k % N));
        return v;
    endfunction

    task automatic send_frame(input bit pt_on_rise, input bit pt_on_fall);
        int n;
        int i0;
        n  = qx.size();
        i0 = 0;
        if (pt_on_rise && n > 0) begin
            step(1, 1, qx[0], qy[0], 0);
            i0 = 1;
        end else begin
            step(1, 0, 0, 0, 0);
        end
        for (int i = i0; i < n; i++) begin
            if (pt_on_fall && i == n - 1) begin
                step(0, 1, qx[i], qy[i], 0);
                return;
            end
            step(1, 1, qx[i], qy[i], 0);
            if ($urandom_range(3) == 0) step(1, 0, 0, 0, 0);
        end
        step(0, 0, 0, 0, 0);
    endtask

    // Drains all rows; ends while the DONE cycle is visible.
    task automatic drain_check(input string tag, input int stall_row, input int ovr_row);
        if (ovr_row >= 0) exp_ovr = 1'b1;
        chk({tag, " cap_cnt"}, pix_cnt, seen.num());
        for (int r = 0; r < N; r++) begin
            int st;
            bit bz;
            bz = (ovr_row >= 0) && (r >= ovr_row);
            chk($sformatf("%s valid r%0d", tag, r), row_valid, 1);
            chk($sformatf("%s idx r%0d", tag, r), row_idx, r);
            chk($sformatf("%s data r%0d", tag, r), row_data, exp_row(r));
            st = (r == stall_row) ? 3 : (($urandom_range(3) == 0) ? $urandom_range(1, 2) : 0);
            for (int s = 0; s < st; s++) begin
                step(bz, bz, $urandom_range(N - 1), $urandom_range(N - 1), 0);
                chk($sformatf("%s held idx r%0d", tag, r), row_idx, r);
                chk($sformatf("%s held data r%0d", tag, r), row_data, exp_row(r));
            end
            step(bz, bz, $urandom_range(N - 1), $urandom_range(N - 1), 1);
        end
        chk({tag, " frame_done"}, frame_done, 1);
        chk({tag, " valid_off"}, row_valid, 0);
        chk({tag, " pix_cnt"}, pix_cnt, seen.num());
        chk({tag, " dup_err"}, dup_err, exp_dup);
        chk({tag, " ovr_err"}, ovr_err, exp_ovr);
    endtask

    task automatic after_idle(input string tag);
        step(0, 0, 0, 0, 0);
        chk({tag, " done_pulse"}, frame_done, 0);
        chk({tag, " idle_valid"}, row_valid, 0);
    endtask

    typedef struct {
        bit rst_n; bit busy; bit p; int x; int y; bit rdy;
        bit ev; int eidx; int edata; int ecnt; bit edone; bit edup; bit eovr;
    } vec_t;
    vec_t tv[$];

    function automatic void addv(input bit rst_n, input bit busy, input bit p, input int x,
                                 input int y, input bit rdy, input bit ev, input int eidx,
                                 input int edata, input int ecnt, input bit edone,
                                 input bit edup, input bit eovr);
        vec_t v;
        v = '{rst_n, busy, p, x, y, rdy, ev, eidx, edata, ecnt, edone, edup, eovr};
        tv.push_back(v);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int px[6];
        int py[6];
        int rows[8];
        int n;
        px   = '{0, 1, 2, 0, 1, 0};
        py   = '{0, 0, 0, 1, 1, 2};
        rows = '{7, 3, 1, 0, 0, 0, 0, 0};
        reset = 1'b0; busy_in = 1'b0; po = 1'b0; rd_ready = 1'b0; xo = '0; yo = '0;
        exp_ovr = 1'b0;
        model_clear();

        // Reset with random inputs, then the basic triangle end to end.
        for (int i = 0; i < 2; i++)
            addv(0, 1'($urandom), 1'($urandom), $urandom_range(N - 1), $urandom_range(N - 1),
                 1'($urandom), 0, 0, 0, 0, 0, 0, 0);
        addv(1, 0, 1, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0);
        addv(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 6; k++) addv(1, 1, 1, px[k], py[k], 0, 0, 0, 0, k + 1, 0, 0, 0);
        addv(1, 0, 0, 0, 0, 1, 1, 0, rows[0], 6, 0, 0, 0);
        for (int r = 1; r < N; r++) addv(1, 0, 0, 0, 0, 1, 1, r, rows[r], 6, 0, 0, 0);
        addv(1, 0, 0, 0, 0, 1, 0, 0, 0, 6, 1, 0, 0);
        addv(1, 0, 0, 0, 0, 0, 0, 0, 0, 6, 0, 0, 0);

        foreach (tv[i]) begin
            reset = tv[i].rst_n;
            step(tv[i].busy, tv[i].p, tv[i].x, tv[i].y, tv[i].rdy);
            chk($sformatf("vec%0d valid", i), row_valid, tv[i].ev);
            if (tv[i].ev || !tv[i].rst_n) begin
                chk($sformatf("vec%0d idx", i), row_idx, tv[i].eidx);
                chk($sformatf("vec%0d data", i), row_data, tv[i].edata);
            end
            chk($sformatf("vec%0d cnt", i), pix_cnt, tv[i].ecnt);
            chk($sformatf("vec%0d done", i), frame_done, tv[i].edone);
            chk($sformatf("vec%0d dup", i), dup_err, tv[i].edup);
            chk($sformatf("vec%0d ovr", i), ovr_err, tv[i].eovr);
        end

        // Duplicate writes.
        model_clear();
        add_pt(3, 3); add_pt(3, 3); add_pt(7, 7);
        send_frame(0, 0);
        drain_check("dup", -1, -1);
        after_idle("dup");

        // Backpressure held on row 2.
        model_clear();
        add_pt(5, 2); add_pt(1, 2); add_pt(4, 3); add_pt(0, 6);
        send_frame(0, 0);
        drain_check("bp", 2, -1);
        after_idle("bp");

        // Overrun: busy rises at row 3 and the lost frame must leave no trace.
        model_clear();
        add_pt(2, 5); add_pt(6, 1);
        send_frame(0, 0);
        drain_check("ovr", -1, 3);
        step(1, 1, 5, 5, 0);
        chk("ovr lost done_pulse", frame_done, 0);
        chk("ovr lost valid", row_valid, 0);
        chk("ovr lost cnt", pix_cnt, seen.num());
        step(1, 1, 6, 6, 0);
        step(0, 0, 0, 0, 0);
        chk("ovr lost no_drain", row_valid, 0);
        chk("ovr sticky", ovr_err, 1);
        model_clear();
        add_pt(7, 0); add_pt(3, 4);
        send_frame(1, 1);
        drain_check("ovr2", -1, -1);
        after_idle("ovr2");

        // New frame rising during DONE, reusing a pixel of the old frame.
        model_clear();
        add_pt(4, 4); add_pt(2, 6); add_pt(4, 4);
        send_frame(0, 1);
        drain_check("dr_a", -1, -1);
        model_clear();
        add_pt(2, 6); add_pt(1, 1);
        send_frame(1, 0);
        drain_check("dr_b", -1, -1);
        after_idle("dr_b");

        // Reset in the middle of a drain.
        model_clear();
        add_pt(0, 0); add_pt(5, 5); add_pt(7, 6);
        send_frame(0, 0);
        for (int r = 0; r < 4; r++) step(0, 0, 0, 0, 1);
        chk("rst_mid idx", row_idx, 4);
        reset = 1'b0;
        step(0, 0, 0, 0, 0);
        chk("rst_mid valid", row_valid, 0);
        chk("rst_mid idx0", row_idx, 0);
        chk("rst_mid data", row_data, 0);
        chk("rst_mid cnt", pix_cnt, 0);
        chk("rst_mid dup", dup_err, 0);
        chk("rst_mid ovr", ovr_err, 0);
        chk("rst_mid done", frame_done, 0);
        reset = 1'b1;
        exp_ovr = 1'b0;
        model_clear();
        add_pt(6, 7); add_pt(1, 3);
        send_frame(0, 0);
        drain_check("rst_new", -1, -1);
        after_idle("rst_new");

        // Random frames, sometimes back to back through DONE.
        for (int f = 0; f < 10; f++) begin
            model_clear();
            n = $urandom_range(0, 14);
            for (int i = 0; i < n; i++) begin
                if (i > 0 && $urandom_range(3) == 0) add_pt(qx[0], qy[0]);
                else add_pt($urandom_range(N - 1), $urandom_range(N - 1));
            end
            send_frame(1'($urandom), 1'($urandom));
            drain_check($sformatf("rnd%0d", f), -1, -1);
            if ($urandom_range(1) == 1) after_idle($sformatf("rnd%0d", f));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/tri_pixel_buffer.md
Name: tri_pixel_buffer

Overview:
- Downstream stage of the triangle rasterizer. Captures the rasterizer's point stream (po/xo/yo) into a 2^COORD_W x 2^COORD_W bitmap while the rasterizer's busy is high.
- When busy falls, drains the bitmap one row per handshake to a consumer (display/checker).
- Reports pixel count, duplicate writes and overrun, then clears itself for the next triangle.

Parameters:
- COORD_W, 3, coordinate width; grid is N=2^COORD_W square; legal range 2..4.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- busy_in  in  1  rasterizer busy; high for the whole triangle.
- po  in  1  point valid from rasterizer.
- xo  in  COORD_W  point x; ignored (may be X/Z) when po=0.
- yo  in  COORD_W  point y; ignored (may be X/Z) when po=0.
- rd_ready  in  1  consumer accepts current row.
- row_valid  out  1  row_idx/row_data valid.
- row_idx  out  COORD_W  row (y) being presented.
- row_data  out  N  bitmap row; bit k = pixel (x=k, y=row_idx).
- pix_cnt  out  2*COORD_W+1  distinct pixels captured in last/current frame.
- frame_done  out  1  one-cycle pulse after last row accepted.
- dup_err  out  1  sticky: a pixel was written twice in the frame.
- ovr_err  out  1  sticky: busy_in rose while draining.

Behaviour:
- Reset (reset=0 at clk edge): state=IDLE, bitmap all 0, busy_d=0, row_valid=0, row_idx=0, row_data=0, pix_cnt=0, frame_done=0, dup_err=0, ovr_err=0. Reset wins over every other event, including mid-CAPTURE and mid-DRAIN.
- busy_d: busy_in registered every cycle. Rise = busy_in & ~busy_d. Fall = ~busy_in & busy_d.

States:
- IDLE: po ignored.
  - On a busy rise: go to CAPTURE, pix_cnt<=0, dup_err<=0.
  - A po in that same cycle is captured; the rasterizer emits no points before busy, but the block must tolerate one.
- CAPTURE: each cycle with po=1:
  - If bit[yo][xo]=0: set it, pix_cnt+1.
  - If bit[yo][xo]=1: no count change, dup_err<=1.
  - On a busy fall: capture any po in that cycle, then go to DRAIN with row_idx=0. row_valid=1 in the next cycle, i.e. 1 cycle after the fall is sampled.
- DRAIN:
  - row_valid=1; row_data=bitmap[row_idx], stable while rd_ready=0.
  - On row_valid & rd_ready: row_idx+1. If row_idx=N-1, go to DONE instead, row_valid<=0.
  - po is ignored.
  - A busy rise sets ovr_err<=1; that frame is lost and is not captured.
- DONE: one cycle.
  - frame_done=1, bitmap cleared to 0, row_idx<=0, go to IDLE.
  - pix_cnt and dup_err hold until the next CAPTURE entry.
  - ovr_err clears only on reset.
  - A busy rise during DONE is treated as an IDLE rise: go straight to CAPTURE and clear the counters; frame_done still pulses.

Arithmetic and throughput:
- pix_cnt is wide enough for N*N (max 64 at default); it never wraps.
- Max throughput: one point per cycle in CAPTURE; one row per cycle in DRAIN with rd_ready held high.
- Minimum drain: N cycles, plus 1 cycle DONE.

Test Plan:
- Reset: hold reset=0 two cycles with random inputs -> all outputs 0, state IDLE; po=1 (2,2) while busy_in=0 -> no capture, pix_cnt stays 0.
- Basic triangle: busy_in=1; points (0,0),(1,0),(2,0),(0,1),(1,1),(0,2); busy_in=0 -> after 1 cycle row_valid=1, with rd_ready=1:
  - rows 0..7 = 0x07,0x03,0x01,0,0,0,0,0 on consecutive cycles;
  - pix_cnt=6, dup_err=0;
  - frame_done pulses one cycle after row 7 is accepted.
- Duplicate: points (3,3),(3,3),(7,7) -> pix_cnt=2, dup_err=1; row3=0x08, row7=0x80.
- Backpressure: rd_ready=0 for 3 cycles while row_idx=2 -> row_idx/row_data held at 2/row2; rd_ready=1 -> advances to 3.
- Overrun and back-to-back frames:
  - busy rise during DRAIN -> ovr_err=1 and stays 1 through the next frame; those points are absent.
  - A second frame after DONE shows a cleared bitmap, containing only its own pixels.
- Reset mid-DRAIN at row_idx=4 -> row_valid=0, bitmap cleared; a subsequent new frame drains correctly from row 0.
